c432_bist_ctrl: RTL and testbench
=================================

# c432_bist_ctrl

Built-in self-test sequencer for the registered c432 wrapper. It generates pseudo-random 36-bit input patterns with an LFSR and drives them onto the wrapper's 36 primary inputs. It compacts the wrapper's 7 registered outputs into a 16-bit MISR signature, then reports pass/fail against a golden signature. It sits beside the c432 wrapper in the ATPG/test harness and shares the wrapper's clock and reset.

## Interface
- `N_PATTERNS`, default 1024: patterns applied per run. Legal range 1..65535.
- `LFSR_SEED`, default 36'h000000001: LFSR load value at start. A value of 0 is replaced by 36'h1.
- `MISR_SEED`, default 16'h0000: MISR load value at start.
- `GOLDEN_SIG`, default 16'h0000: expected final signature.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `abort`  in  1  synchronous cancel; effective in APPLY or DRAIN.
- `pat_out`  out  36  pattern to wrapper inputs. Bit 0 drives N1_wire; bits 1..35 drive N4_wire..N115_wire in declaration order.
- `resp_in`  in  7  wrapper registered outputs `{N432,N431,N430,N421,N370,N329,N223}`, with bit 0 = N223.
- `busy`  out  1  high in APPLY and DRAIN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid while done; 1 when the signature equals GOLDEN_SIG.
- `signature`  out  16  current MISR contents.

## Operation
- States: IDLE, APPLY, DRAIN, DONE.
- Reset (async) gives:
  - state = IDLE
  - lfsr = 0, misr = 0, pat_cnt = 0, drain_cnt = 0, vld[1:0] = 0
  - busy = 0, done = 0, pass = 0, signature = 0, pat_out = 0
- IDLE or DONE with start = 1 goes to APPLY, and on that edge:
  - lfsr ← LFSR_SEED (0 → 1), misr ← MISR_SEED, pat_cnt ← 0, drain_cnt ← 0
  - done ← 0, pass ← 0
- Start during APPLY or DRAIN is ignored.
- APPLY:
  - pat_out = lfsr; outside APPLY, pat_out = 0.
  - Each edge: lfsr ← {lfsr[34:0], lfsr[35]^lfsr[24]} and pat_cnt ← pat_cnt+1.
  - When pat_cnt == N_PATTERNS-1, go to DRAIN.
- Valid pipeline, every edge: vld[0] ← (state == APPLY); vld[1] ← vld[0]. This matches the wrapper's input-register plus output-register latency of 2.
- MISR, on each edge with vld[1] = 1:
  - misr ← {misr[14:0], fb} ^ {9'b0, resp_in}
  - fb = misr[15]^misr[14]^misr[12]^misr[3]
  - Exactly N_PATTERNS updates occur per completed run.
- DRAIN lasts 3 cycles (drain_cnt 0..2). On the edge leaving drain_cnt == 2:
  - state ← DONE
  - pass ← (misr == GOLDEN_SIG)
- DONE holds done = 1 and keeps pass and signature stable until the next start.
- Abort in APPLY or DRAIN:
  - state ← IDLE, vld ← 0, done and pass stay 0, signature holds its partial value.
  - Abort takes priority over the pat_cnt and drain_cnt transitions.
- Abort in IDLE or DONE has no effect. If start and abort are both high in DONE, start wins.
- Reset mid-run returns all state to reset values immediately, regardless of clock.

## Timing
- Start sampled at edge E0.
- Pattern k (k = 0..N-1) is on pat_out during the cycle after E_k.
- The response to pattern k is on resp_in after E_(k+2) and is compacted at E_(k+3).
- Last compaction occurs at E_(N+2).
- DONE is entered at E_(N+3): done and pass are valid N+3 cycles after the start edge.
- busy rises at E0 and falls at E_(N+3), so busy is high for N+3 cycles.
- Back-to-back runs: start held high in DONE restarts on the next edge, with no extra idle cycle.

## Test plan
- **Reset values.** Assert reset mid-APPLY with N_PATTERNS=8 → immediately busy=0, done=0, pass=0, signature=16'h0000, pat_out=0. After release the block stays IDLE until start.
- **LFSR sequence.** LFSR_SEED=1, N=4 → pat_out reads 36'h1, 36'h2, 36'h4, 36'h8 on consecutive cycles, then 0 in DRAIN.
  - LFSR_SEED=36'h800000000 → second pattern 36'h000000001.
- **Zero response.** MISR_SEED=0, GOLDEN_SIG=0, N=4, resp_in=0 → signature stays 16'h0000; done and pass=1 exactly 7 cycles after the start edge; busy high for 7 cycles.
- **MISR arithmetic.** MISR_SEED=0, resp_in held at 7'h01:
  - N=1 → signature 16'h0001; pass=1 with GOLDEN_SIG=16'h0001.
  - N=2 → signature 16'h0003; pass=0 with GOLDEN_SIG=16'h0001.
- **Abort and ignored start.** N=16, pulse start again at cycle 5 → no restart, pat_cnt unaffected. Abort at cycle 10 → IDLE on the next edge, done=0, pass=0. A subsequent start runs the full 19-cycle sequence from the seed.
- **Closed loop with the c432 wrapper.** Default parameters → done after 1027 cycles. GOLDEN_SIG taken from a reference run gives pass=1. Forcing any wrapper output stuck-at-0 gives pass=0.

Source files
------------

// File: rtl/c432_bist_ctrl.sv
// BIST sequencer for the registered c432 wrapper.
// A 36-bit LFSR drives the wrapper inputs, and a 16-bit MISR compacts the wrapper outputs.
// When a run completes, the final signature is compared against a golden value.
module c432_bist_ctrl #(
  parameter int unsigned N_PATTERNS = 1024,
  parameter logic [35:0] LFSR_SEED  = 36'h000000001,
  parameter logic [15:0] MISR_SEED  = 16'h0000,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [35:0] pat_out,
  input  logic [6:0]  resp_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [1:0] {StIdle, StApply, StDrain, StDone} state_e;

  // An all-zero seed would lock the LFSR, so substitute 1.
  localparam logic [35:0] SeedEff = (LFSR_SEED == 36'h0) ? 36'h1 : LFSR_SEED;
  localparam logic [15:0] LastPat = 16'(N_PATTERNS - 1);

  state_e      state_q;
  logic [35:0] lfsr_q;
  logic [15:0] misr_q;
  logic [15:0] pat_cnt_q;
  logic [1:0]  drain_cnt_q;
  logic [1:0]  vld_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;

  logic [35:0] lfsr_next;
  logic [15:0] misr_next;
  logic        misr_fb;

  // Next-value functions for the pattern generator and the response compactor.
  always_comb begin
    lfsr_next = {lfsr_q[34:0], lfsr_q[35] ^ lfsr_q[24]};
    misr_fb   = misr_q[15] ^ misr_q[14] ^ misr_q[12] ^ misr_q[3];
    misr_next = {misr_q[14:0], misr_fb} ^ {9'b0, resp_in};
  end

  // Sequencer: controls state, the pattern and drain counters, the LFSR, the MISR and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      lfsr_q      <= '0;
      misr_q      <= '0;
      pat_cnt_q   <= '0;
      drain_cnt_q <= '0;
      vld_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      // vld tracks the two-register latency through the wrapper.
      vld_q <= {vld_q[0], state_q == StApply};
      if (vld_q[1]) begin
        misr_q <= misr_next;
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StApply;
            lfsr_q      <= SeedEff;
            misr_q      <= MISR_SEED;
            pat_cnt_q   <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        StApply: begin
          if (abort) begin
            // The partial signature is frozen, including any compaction due on this edge.
            state_q <= StIdle;
            vld_q   <= '0;
            misr_q  <= misr_q;
            busy_q  <= 1'b0;
          end else begin
            lfsr_q    <= lfsr_next;
            pat_cnt_q <= pat_cnt_q + 16'd1;
            if (pat_cnt_q == LastPat) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (abort) begin
            state_q <= StIdle;
            vld_q   <= '0;
            misr_q  <= misr_q;
            busy_q  <= 1'b0;
          end else if (drain_cnt_q == 2'd2) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (misr_q == GOLDEN_SIG);
          end else begin
            drain_cnt_q <= drain_cnt_q + 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Patterns are presented only while applying, so the wrapper sees zeros otherwise.
  assign pat_out   = (state_q == StApply) ? lfsr_q : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule

// File: tb/tb_c432_bist_ctrl.sv
// Bench for c432_bist_ctrl: small instances are checked against literal values.
// One main instance, fed by a stand-in registered wrapper, is checked every cycle against
// a behavioural model.
module tb_c432_bist_ctrl;

  localparam int          NM      = 16;
  localparam logic [35:0] SEED_M  = 36'h5A5A5A5A5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [6:0] r);
    logic fb;
    fb = s[15] ^ s[14] ^ s[12] ^ s[3];
    return {s[14:0], fb} ^ {9'b0, r};
  endfunction

  // ---------------- small instances: literal expectations ----------------
  logic        start_s = 1'b0;
  logic [35:0] pat_s [4];
  logic        busy_s [4];
  logic        done_s [4];
  logic        pass_s [4];
  logic [15:0] sig_s [4];

  c432_bist_ctrl #(.N_PATTERNS(4), .LFSR_SEED(36'h1), .MISR_SEED(16'h0), .GOLDEN_SIG(16'h0))
    dut_a (.clk(clk), .reset(reset), .start(start_s), .abort(1'b0), .pat_out(pat_s[0]),
           .resp_in(7'h00), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
           .signature(sig_s[0]));
  c432_bist_ctrl #(.N_PATTERNS(4), .LFSR_SEED(36'h800000000), .MISR_SEED(16'h0),
                   .GOLDEN_SIG(16'h0))
    dut_b (.clk(clk), .reset(reset), .start(start_s), .abort(1'b0), .pat_out(pat_s[1]),
           .resp_in(7'h00), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
           .signature(sig_s[1]));
  c432_bist_ctrl #(.N_PATTERNS(1), .LFSR_SEED(36'h1), .MISR_SEED(16'h0), .GOLDEN_SIG(16'h0001))
    dut_c (.clk(clk), .reset(reset), .start(start_s), .abort(1'b0), .pat_out(pat_s[2]),
           .resp_in(7'h01), .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
           .signature(sig_s[2]));
  c432_bist_ctrl #(.N_PATTERNS(2), .LFSR_SEED(36'h1), .MISR_SEED(16'h0), .GOLDEN_SIG(16'h0001))
    dut_d (.clk(clk), .reset(reset), .start(start_s), .abort(1'b0), .pat_out(pat_s[3]),
           .resp_in(7'h01), .busy(busy_s[3]), .done(done_s[3]), .pass(pass_s[3]),
           .signature(sig_s[3]));

  // ---------------- main instance with a stand-in wrapper ----------------
  logic        start_m = 1'b0;
  logic        abort_m = 1'b0;
  logic        zero_mode = 1'b1;
  logic [35:0] pat_m;
  logic [6:0]  resp_m;
  logic        busy_m, done_m, pass_m;
  logic [15:0] sig_m;
  logic [35:0] w_in_q;
  logic [6:0]  w_out_q;

  c432_bist_ctrl #(.N_PATTERNS(NM), .LFSR_SEED(SEED_M), .MISR_SEED(16'h0), .GOLDEN_SIG(16'h0))
    dut_m (.clk(clk), .reset(reset), .start(start_m), .abort(abort_m), .pat_out(pat_m),
           .resp_in(resp_m), .busy(busy_m), .done(done_m), .pass(pass_m), .signature(sig_m));

  // Stand-in for the wrapper: input register, fold logic, output register.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      w_in_q  <= '0;
      w_out_q <= '0;
    end else begin
      w_in_q  <= pat_m;
      w_out_q <= w_in_q[6:0] ^ w_in_q[13:7] ^ w_in_q[20:14] ^ w_in_q[27:21] ^ w_in_q[34:28]
                 ^ {6'b0, w_in_q[35]};
    end
  end
  assign resp_m = zero_mode ? 7'h00 : w_out_q;

  // Model: the run is a count of edges since the start edge. Pattern c is shown at count c.
  // The response seen at count c (2..N+1) is compacted, and the run completes at count N+3.
  logic [35:0] pats [NM];
  logic        m_run = 1'b0, m_done = 1'b0, m_pass = 1'b0;
  logic [15:0] m_sig = 16'h0;
  int          m_c = 0;

  initial begin
    pats[0] = SEED_M;
    for (int i = 1; i < NM; i++) pats[i] = {pats[i-1][34:0], pats[i-1][35] ^ pats[i-1][24]};
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_sig = 16'h0; m_c = 0;
    end else if (m_run) begin
      if (abort_m) begin
        m_run = 1'b0;
      end else begin
        if (m_c >= 2 && m_c <= NM + 1) m_sig = misr_step(m_sig, resp_m);
        m_c++;
        if (m_c == NM + 3) begin
          m_run = 1'b0; m_done = 1'b1; m_pass = (m_sig == 16'h0);
        end
      end
    end else if (start_m) begin
      m_run = 1'b1; m_c = 0; m_sig = 16'h0; m_done = 1'b0; m_pass = 1'b0;
    end
  end

  // Per-cycle comparison of the main instance against the model.
  always begin
    @(posedge clk);
    #2;
    if (!reset) begin
      chk("m_pat", pat_m, (m_run && m_c < NM) ? pats[m_c] : 36'h0);
      chk("m_busy", busy_m, m_run);
      chk("m_done", done_m, m_done);
      chk("m_pass", pass_m, m_pass);
      chk("m_sig", sig_m, m_sig);
    end
  end

  task automatic pulse_start_m();
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
  endtask

  initial begin
    // Model pins, computed by hand.
    chk("pin_step_01", misr_step(16'h0000, 7'h01), 16'h0001);
    chk("pin_step_03", misr_step(16'h0001, 7'h01), 16'h0003);
    chk("pin_step_fb", misr_step(16'h8000, 7'h00), 16'h0001);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_pass", pass_m, 0);
    chk("rst_sig", sig_m, 0);
    chk("rst_pat", pat_m, 0);

    // Small instances; c is the number of edges since the start edge.
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("a_pat", pat_s[0], (c < 4) ? (64'h1 << c) : 64'h0);
      chk("a_busy", busy_s[0], c < 7);
      chk("a_done", done_s[0], c >= 7);
      chk("a_pass", pass_s[0], c >= 7);
      chk("a_sig", sig_s[0], 0);
      if (c == 0) chk("b_pat0", pat_s[1], 36'h800000000);
      if (c == 1) chk("b_pat1", pat_s[1], 36'h000000001);
      chk("c_sig", sig_s[2], (c >= 3) ? 16'h0001 : 16'h0000);
      chk("c_done", done_s[2], c >= 4);
      chk("c_pass", pass_s[2], c >= 4);
      chk("d_sig", sig_s[3], (c >= 4) ? 16'h0003 : ((c >= 3) ? 16'h0001 : 16'h0000));
      chk("d_done", done_s[3], c >= 5);
      chk("d_pass", pass_s[3], 0);
      @(negedge clk);
    end

    // Main: zero-response run, so completion and pass come after NM+3 cycles.
    pulse_start_m();
    repeat (NM + 3) @(negedge clk);
    chk("m_zero_done", done_m, 1);
    chk("m_zero_pass", pass_m, 1);
    chk("m_zero_sig", sig_m, 16'h0000);

    // Main: live responses. A second start is ignored, and an abort returns to idle.
    zero_mode = 1'b0;
    pulse_start_m();
    repeat (4) @(negedge clk);
    pulse_start_m();
    repeat (4) @(negedge clk);
    abort_m = 1'b1;
    @(negedge clk);
    abort_m = 1'b0;
    chk("m_abort_busy", busy_m, 0);
    chk("m_abort_done", done_m, 0);
    chk("m_abort_pass", pass_m, 0);
    repeat (3) @(negedge clk);

    // Full run, then start held in DONE to restart immediately.
    pulse_start_m();
    repeat (NM + 3) @(negedge clk);
    chk("m_full_done", done_m, 1);
    pulse_start_m();
    chk("m_b2b_busy", busy_m, 1);
    chk("m_b2b_done", done_m, 0);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-apply, away from any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", busy_m, 0);
    chk("arst_done", done_m, 0);
    chk("arst_pass", pass_m, 0);
    chk("arst_sig", sig_m, 0);
    chk("arst_pat", pat_m, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_rst", busy_m, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
